// File: rtl/dec_pkg.sv
// Shared types and helpers for the binary-to-decimal serial converter.
package dec_pkg;

  localparam int DEC_LINES = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
  endfunction

endpackage

// File: rtl/bcd_to_onehot.sv
// Combinational 4-bit BCD to one-hot decimal lines; codes 10..15 decode to all zero.
module bcd_to_onehot
  import dec_pkg::*;
(
  input  logic [3:0]           bcd_i,
  output logic [DEC_LINES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    case (bcd_i)
      4'd0:    onehot_o = 10'b00_0000_0001;
      4'd1:    onehot_o = 10'b00_0000_0010;
      4'd2:    onehot_o = 10'b00_0000_0100;
      4'd3:    onehot_o = 10'b00_0000_1000;
      4'd4:    onehot_o = 10'b00_0001_0000;
      4'd5:    onehot_o = 10'b00_0010_0000;
      4'd6:    onehot_o = 10'b00_0100_0000;
      4'd7:    onehot_o = 10'b00_1000_0000;
      4'd8:    onehot_o = 10'b01_0000_0000;
      4'd9:    onehot_o = 10'b10_0000_0000;
      default: onehot_o = 10'b00_0000_0000;
    endcase
  end

endmodule

// File: rtl/binary_to_decimal_serial.sv
// Serial double-dabble binary-to-decimal converter streaming one-hot digits MSD first.
// Define LEADING_ZERO_SUPPRESS_EN to start each stream at the highest nonzero digit.
module binary_to_decimal_serial
  import dec_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int IDXW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DEC_LINES-1:0] out_dec,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);

  state_e                 state_q;
  logic [WIDTH-1:0]       shreg_q;
  logic [BCDW-1:0]        bcd_q;
  logic [CNTW-1:0]        cnt_q;
  logic [IDXW-1:0]        ptr_q;

  logic [BCDW-1:0]        bcd_adj_s;
  logic [BCDW-1:0]        bcd_d;
  logic [WIDTH-1:0]       shreg_d;
  logic [IDXW-1:0]        start_ptr_d;
  logic [IDXW-1:0]        sel_idx_s;
  logic [BCDW-1:0]        sel_src_s;
  logic [3:0]             nibble_s;
  logic [DEC_LINES-1:0]   dec_s;

  assign in_ready = (state_q == IDLE) && !rst;

  // One correction-and-shift step of the conversion.
  always_comb begin
    bcd_adj_s = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj_s[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
    {bcd_d, shreg_d} = {bcd_adj_s, shreg_q} << 1;
  end

  // First digit position to emit once the final shift lands.
  always_comb begin
`ifdef LEADING_ZERO_SUPPRESS_EN
    start_ptr_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_d[4*i +: 4] != 4'd0) begin
        start_ptr_d = IDXW'(i);
      end else begin
        start_ptr_d = start_ptr_d;
      end
    end
`else
    start_ptr_d = IDXW'(DIGITS - 1);
`endif
  end

  // The digit loaded next: the first one on EMIT entry, else the one below ptr.
  always_comb begin
    if (state_q == CONVERT) begin
      sel_idx_s = start_ptr_d;
      sel_src_s = bcd_d;
    end else if (ptr_q != '0) begin
      sel_idx_s = ptr_q - 1'b1;
      sel_src_s = bcd_q;
    end else begin
      sel_idx_s = '0;
      sel_src_s = bcd_q;
    end
    nibble_s = 4'(sel_src_s >> (4 * int'(sel_idx_s)));
  end

  bcd_to_onehot u_dec (
    .bcd_i    (nibble_s),
    .onehot_o (dec_s)
  );

  // Conversion FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_dec   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_q <= in_bin;
            bcd_q   <= '0;
            cnt_q   <= CNTW'(WIDTH);
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q   <= bcd_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            state_q   <= EMIT;
            ptr_q     <= start_ptr_d;
            out_valid <= 1'b1;
            out_dec   <= dec_s;
            out_idx   <= start_ptr_d;
            out_last  <= (start_ptr_d == '0);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (ptr_q == '0) begin
              state_q   <= IDLE;
              out_valid <= 1'b0;
              out_dec   <= '0;
              out_idx   <= '0;
              out_last  <= 1'b0;
            end else begin
              ptr_q    <= ptr_q - 1'b1;
              out_dec  <= dec_s;
              out_idx  <= ptr_q - 1'b1;
              out_last <= (ptr_q == IDXW'(1));
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          out_dec   <= '0;
          out_idx   <= '0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/binary_to_decimal_serial.md
Name: binary_to_decimal_serial

Overview:
- Converts a WIDTH-bit unsigned binary value into decimal digits using serial double-dabble (shift-add-3), one shift per clock.
- Emits each digit MSD first as one-hot decimal lines d0..d9 over a valid/ready stream.
- Inverse of the team's decimal-to-binary encoder; drives decimal display/indicator logic from binary datapaths.

Parameters:
- WIDTH, 8: binary input width; 1..16.
- DIGITS, 3: number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH-1.
- IDXW, 2: out_idx width; must satisfy 2^IDXW >= DIGITS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bin is valid.
- in_ready  out  1  block accepts input; high only in IDLE.
- in_bin  in  WIDTH  binary value to convert.
- out_valid  out  1  out_dec/out_idx/out_last are valid.
- out_ready  in  1  downstream accepts the current digit.
- out_dec  out  10  one-hot digit; bit k set means digit k; all zero when out_valid=0.
- out_idx  out  IDXW  digit position; 0 = least significant.
- out_last  out  1  current beat is the least significant digit.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset: state=IDLE, out_valid=0, out_dec=0, out_idx=0, out_last=0, BCD and shift registers cleared.
  - in_ready = (state==IDLE) && !rst, so in_ready is 0 while rst is high and 1 from the first cycle after.
- States: IDLE -> CONVERT -> EMIT -> IDLE.
- IDLE:
  - On in_valid && in_ready, latch in_bin, clear the BCD register, load cnt=WIDTH, go to CONVERT.
  - in_valid while busy is ignored; the source must hold it until in_ready.
- CONVERT, one cycle per bit:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, shreg} shifts left by 1; cnt decrements.
  - After WIDTH cycles, go to EMIT with digit pointer = DIGITS-1.
- EMIT:
  - out_valid=1; out_dec=onehot(bcd nibble[ptr]); out_idx=ptr; out_last=(ptr==0).
  - Outputs are registered and stable while out_valid && !out_ready.
  - On out_valid && out_ready: if ptr==0, go to IDLE and drop out_valid next cycle; otherwise ptr decrements.
- Latency: accept at cycle t; first out_valid at t+WIDTH+1. With out_ready held high, last digit at t+WIDTH+DIGITS.
- Throughput: one conversion per WIDTH+DIGITS+1 cycles minimum. in_ready returns the cycle after the last handshake; no overlap.
- Boundary conditions:
  - in_bin=0 yields all-zero digits.
  - in_bin=2^WIDTH-1 must not overflow DIGITS (guaranteed by the parameter rule).
  - A nibble >9 is impossible by construction. The decoder maps codes 10..15 to out_dec=0, for bench checking.
- rst mid-CONVERT or mid-EMIT: aborts immediately, the in-flight value is discarded, and no partial digit appears after reset.
- out_ready may be high when out_valid=0; it has no effect.

Optional Feature:
- Macro: LEADING_ZERO_SUPPRESS_EN.
- Defined: on entry to EMIT, ptr starts at the highest nonzero digit (0 if the value is 0), so leading zeros are never emitted.
  - 255 gives 3 beats; 7 gives 1 beat (idx 0, last); 0 gives 1 beat of digit 0.
- Undefined: always exactly DIGITS beats, MSD first, leading zeros included.

Decomposition:
- Package dec_pkg:
  - localparam DEC_LINES=10.
  - State enum {IDLE, CONVERT, EMIT}.
  - Function add3 (nibble >= 5 ? nibble+3 : nibble).
- Sub-module bcd_to_onehot: combinational 4-bit BCD to 10-bit one-hot; invalid codes give 0.
  - Reusable as the exact inverse of the existing decimal encoder.
- Top-level holds the FSM, shift/BCD registers, pointer and output registers.

Test Plan:
- Reset, then in_bin=255 with out_ready=1 -> beats 10'b0000000100 (idx2), 10'b0000100000 (idx1), 10'b0000100000 (idx0, last=1); first out_valid at accept+9.
- in_bin=0 -> three beats of 10'b0000000001 (feature off); one beat, idx0, last=1 (feature on).
- in_bin=7, out_ready low for 5 cycles on each beat -> outputs held constant while stalled; digits 0,0,7 (off) or only 7 (on); no beat lost or duplicated.
- in_valid held high across back-to-back inputs 128 then 9 -> in_ready low throughout conversion; digit streams 1,2,8 then 0,0,9; second accept only after out_last handshake.
- rst pulsed 1 cycle mid-CONVERT (in_bin=200), then in_bin=42 -> no digit of 200 ever appears; output is 0,4,2.
- Exhaustive 0..255 with random out_ready -> reconstructed sum(digit*10^idx) equals the input; out_dec always one-hot when valid, zero when not valid.
